acc_cpu_port: RTL

Accelerator-side responder for the CPU EX-stage accelerator interface. It accepts one `acc_instr_t` at a time from the CPU and hands it to the accelerator core over a valid/ready command port. It then waits for the core's result and writes that result back into the CPU register file through the `waddr/wdata/wren` port. In parallel it buffers the CPU's forwarded load data (`fwd_data`) for the pivot datapath. It sits between the CPU pipeline and the FPU/pivot engine inside `acc_top`.

---
 rtl/acc_cpu_port.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_port.sv
// ============================================================================
// acc_cpu_port
// ----------------------------------------------------------------------------
// Accelerator-side responder for the CPU EX-stage accelerator interface.
// Takes one instruction at a time from the CPU and hands it to the
// accelerator core over a valid/ready command port. It then waits for the
// core's result and writes it back into the CPU register file. Alongside
// this, it buffers forwarded load data from the CPU WB stage for the pivot
// datapath.
//
// Build option:
//   ACC_CPU_PORT_FWD_FIFO_EN  defined   -> FWD_DEPTH-entry forwarded-data FIFO
//                             undefined -> combinational pass-through, no
//                                          storage, FWD_DEPTH only
//                                          range-checked
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   acc_instr_i/_valid_i          instruction from the CPU (one-cycle pulse)
//   busy_o, ready_o               instruction in flight / can accept
//   waddr_o, wdata_o, wren_o      register-file writeback (zeroed when idle)
//   fwd_data_i, fwd_valid_i       forwarded load data from the CPU
//   cmd_o, cmd_valid_o/ready_i    latched instruction to the core
//   res_data_i, res_valid_i/ready_o  result from the core
//   fwd_data_o, fwd_valid_o/ready_i  forwarded-data FIFO head
//   err_o                         sticky: [0] fwd overflow, [1] instr dropped
// ============================================================================

package acc_cpu_port_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] data_t;

    // acc_op: 0 = FPU operation, 1 = ACC (pivot engine) operation
    typedef struct packed {
        logic      acc_op;
        logic [3:0] op;
        reg_addr_t rd;
        data_t     rs1;
        data_t     rs2;
    } acc_instr_t;

    localparam logic [3:0] OP_FADD   = 4'd0;
    localparam logic [3:0] OP_FMUL   = 4'd2;
    localparam logic [3:0] OP_FDIV   = 4'd3;
    localparam logic [3:0] OP_PREPIV = 4'd8;
    localparam logic [3:0] OP_PIVOT  = 4'd9;

endpackage

module acc_cpu_port
    import acc_cpu_port_pkg::*;
#(
    parameter int FWD_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,

    input  acc_instr_t acc_instr_i,
    input  logic       acc_instr_valid_i,
    output logic       busy_o,
    output logic       ready_o,

    output reg_addr_t  waddr_o,
    output data_t      wdata_o,
    output logic       wren_o,

    input  data_t      fwd_data_i,
    input  logic       fwd_valid_i,

    output acc_instr_t cmd_o,
    output logic       cmd_valid_o,
    input  logic       cmd_ready_i,

    input  data_t      res_data_i,
    input  logic       res_valid_i,
    output logic       res_ready_o,

    output data_t      fwd_data_o,
    output logic       fwd_valid_o,
    input  logic       fwd_ready_i,

    output logic [1:0] err_o
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity check
    // ------------------------------------------------------------------------
    generate
        if (FWD_DEPTH < 2 || (FWD_DEPTH & (FWD_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("acc_cpu_port: FWD_DEPTH must be a power of two >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Instruction FSM
    // ------------------------------------------------------------------------
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] WB    = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    acc_instr_t cmd_q;
    data_t      res_q;

    logic accept;
    logic drop;
    logic res_take;

    assign accept   = (state == IDLE) && acc_instr_valid_i;
    // Only one instruction may be in flight; a second pulse is lost.
    assign drop     = (state != IDLE) && acc_instr_valid_i;
    assign res_take = (state == WAIT) && res_valid_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc_instr_valid_i) state_nxt = ISSUE;
            ISSUE:   if (cmd_ready_i)       state_nxt = WAIT;
            // rd == x0 needs no writeback, so skip WB entirely
            WAIT:    if (res_valid_i)       state_nxt = (cmd_q.rd != '0) ? WB : IDLE;
            WB:                             state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cmd_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept)   cmd_q <= acc_instr_i;
            if (res_take) res_q <= res_data_i;
        end
    end

    // All handshake/status outputs are pure decodes of the registered state.
    assign ready_o     = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign cmd_valid_o = (state == ISSUE);
    assign res_ready_o = (state == WAIT);
    assign cmd_o       = cmd_q;

    assign wren_o  = (state == WB);
    assign waddr_o = wren_o ? cmd_q.rd : '0;
    assign wdata_o = wren_o ? res_q    : '0;

    // ------------------------------------------------------------------------
    // Forwarded-data path
    // ------------------------------------------------------------------------
    logic fwd_ovf;

`ifdef ACC_CPU_PORT_FWD_FIFO_EN
    localparam int AW = $clog2(FWD_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    data_t       mem [FWD_DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && fwd_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = fwd_valid_i && (!full || pop);
    assign fwd_ovf = fwd_valid_i && full && !pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= fwd_data_i;
    end

    assign fwd_valid_o = !empty;
    assign fwd_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
    // No storage: a word not taken in the cycle it is offered is lost.
    assign fwd_valid_o = fwd_valid_i;
    assign fwd_data_o  = fwd_data_i;
    assign fwd_ovf     = fwd_valid_i && !fwd_ready_i;
`endif

    // ------------------------------------------------------------------------
    // Sticky error flags, cleared only by reset
    // ------------------------------------------------------------------------
    logic [1:0] err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else begin
            if (fwd_ovf) err_q[0] <= 1'b1;
            if (drop)    err_q[1] <= 1'b1;
        end
    end

    assign err_o = err_q;

endmodule
